pulse_sequencer: RTL and testbench

- Symbol sequencer feeding the carrier generator and the output pin.
- Buffers (level, duration) symbols in a small FIFO and plays them back-to-back with cycle-exact timing.
- Drives the carrier enable so each mark starts phase-aligned.
- Optionally gates the received carrier onto marks to form the final modulated output.

---
 rtl/pulse_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_pulse_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pulse_sequencer.sv
// Buffers (level, duration) symbols and plays them back-to-back, cycle-exact, with carrier gating.
// Optional build macro PULSE_SEQ_LOOP_EN: replays the buffered pass loop_count+1 times.
module pulse_sequencer #(
   parameter int unsigned TIMER_WIDTH = 16,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                        clk,
   input  logic                        sys_rst_n,
   input  logic                        sym_valid,
   output logic                        sym_ready,
   input  logic                        sym_level,
   input  logic [TIMER_WIDTH-1:0]      sym_duration,
   input  logic                        start,
   input  logic                        stop,
   input  logic                        flush,
   input  logic                        idle_level,
   input  logic                        carrier_mod,
   input  logic                        carrier_in,
`ifdef PULSE_SEQ_LOOP_EN
   input  logic [7:0]                  loop_count,
`endif
   output logic                        carrier_gate,
   output logic                        out,
   output logic                        busy,
   output logic                        done,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;
   typedef struct packed {
      logic                   level;
      logic [TIMER_WIDTH-1:0] dur;
   } sym_t;

   state_t                 state_q, state_d;
   sym_t                   mem_q [FIFO_DEPTH];
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, nxt_ptr;
   logic [CW-1:0]          count_q, count_d, free_n;
   logic                   level_q, level_d;
   logic [TIMER_WIDTH-1:0] cnt_q, cnt_d;
   logic                   done_q, done_d, gate_q, gate_d, base_q, base_d;
   logic                   load, fin, more, pop, wr_en;

`ifdef PULSE_SEQ_LOOP_EN
   logic [PW-1:0] play_ptr_q, play_ptr_d, pos_q, pos_d;
   logic [CW-1:0] pass_len_q, pass_len_d;
   logic [7:0]    pass_q, pass_d, loops_q, loops_d;
   logic          in_pass, is_final, is_first;

   assign in_pass  = (CW'(pos_q) + CW'(1)) < pass_len_q;
   assign is_final = (pass_q == loops_q);
   assign is_first = (pass_q == 8'd0);
   assign more     = in_pass || !is_final;
   assign sym_ready = (count_q != CW'(FIFO_DEPTH)) && (state_q != S_RUN);
`else
   assign more      = (count_q != '0);
   assign sym_ready = (count_q != CW'(FIFO_DEPTH));
`endif

   assign busy         = (state_q == S_RUN);
   assign done         = done_q;
   assign carrier_gate = gate_q;
   assign fifo_count   = count_q;
   // Carrier passes straight through during marks; everything else comes from registers.
   assign out          = gate_q ? carrier_in : base_q;

   // FSM state register
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state_q <= S_IDLE;
      else            state_q <= state_d;
   end

   // FSM next-state logic; abort (stop/flush) has priority over reload and completion
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      fin     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && !stop && !flush && (count_q != '0)) begin
               load    = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (stop || flush) begin
               state_d = S_IDLE;
            end else if (cnt_q == '0) begin
               if (more) begin
                  load = 1'b1;
               end else begin
                  fin     = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FIFO pointer and occupancy update
   always_comb begin
      nxt_ptr = rd_ptr_q;
      pop     = load;
      free_n  = '0;
`ifdef PULSE_SEQ_LOOP_EN
      pop = 1'b0;
      if (state_q == S_IDLE) begin
         pop = load && (loop_count == 8'd0);
      end else if (in_pass) begin
         nxt_ptr = play_ptr_q + PW'(1);
         pop     = load && is_final;
      end else begin
         pop = load && ((pass_q + 8'd1) == loops_q);
      end
      // Entries already played but still held for later passes are released on stop.
      if ((state_q == S_RUN) && stop && !flush) begin
         if (is_final) free_n = is_first ? '0 : (pass_len_q - CW'(pos_q) - CW'(1));
         else          free_n = is_first ? (CW'(pos_q) + CW'(1)) : pass_len_q;
      end
`endif
      wr_en    = sym_valid && sym_ready && !flush;
      wr_ptr_d = wr_ptr_q + PW'(wr_en);
      if (flush) begin
         count_d  = '0;
         rd_ptr_d = wr_ptr_q;
      end else begin
         count_d  = count_q + CW'(wr_en) - CW'(pop) - free_n;
         rd_ptr_d = rd_ptr_q + PW'(pop) + free_n[PW-1:0];
      end
   end

   // FSM output / symbol datapath next values
   always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      if (load) begin
         level_d = mem_q[nxt_ptr].level;
         cnt_d   = mem_q[nxt_ptr].dur;
      end else if ((state_q == S_RUN) && (cnt_q != '0)) begin
         cnt_d = cnt_q - TIMER_WIDTH'(1);
      end
      done_d = fin;
      gate_d = (state_d == S_RUN) && level_d && carrier_mod;
      base_d = (state_d == S_RUN) ? level_d : idle_level;
`ifdef PULSE_SEQ_LOOP_EN
      play_ptr_d = load ? nxt_ptr : play_ptr_q;
      pos_d      = pos_q;
      pass_d     = pass_q;
      loops_d    = loops_q;
      pass_len_d = pass_len_q;
      if (load && (state_q == S_IDLE)) begin
         pos_d      = '0;
         pass_d     = 8'd0;
         loops_d    = loop_count;
         pass_len_d = count_q;
      end else if (load) begin
         if (in_pass) begin
            pos_d = pos_q + PW'(1);
         end else begin
            pos_d  = '0;
            pass_d = pass_q + 8'd1;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= '{level: sym_level, dur: sym_duration};
   end

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         level_q  <= 1'b0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         gate_q   <= 1'b0;
         base_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         level_q  <= level_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         gate_q   <= gate_d;
         base_q   <= base_d;
      end
   end

`ifdef PULSE_SEQ_LOOP_EN
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         play_ptr_q <= '0;
         pos_q      <= '0;
         pass_q     <= 8'd0;
         loops_q    <= 8'd0;
         pass_len_q <= '0;
      end else begin
         play_ptr_q <= play_ptr_d;
         pos_q      <= pos_d;
         pass_q     <= pass_d;
         loops_q    <= loops_d;
         pass_len_q <= pass_len_d;
      end
   end
`endif

endmodule

// File: tb/tb_pulse_sequencer.sv
// Bench for pulse_sequencer: directed scenarios plus randomized symbol streams against a queue model.
module tb_pulse_sequencer;
   localparam int unsigned TW    = 16;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0, sys_rst_n = 1'b0;
   logic          sym_valid = 1'b0, sym_level = 1'b0;
   logic [TW-1:0] sym_duration = '0;
   logic          start = 1'b0, stop = 1'b0, flush = 1'b0;
   logic          idle_level = 1'b0, carrier_mod = 1'b0, carrier_in = 1'b0;
   logic          sym_ready, carrier_gate, out, busy, done;
   logic [CW-1:0] fifo_count;
`ifdef PULSE_SEQ_LOOP_EN
   logic [7:0]    loop_count = 8'd0;
`endif

   typedef struct { logic lvl; int dur; } sym_t;
   sym_t q[$];
   int   checks = 0, errors = 0;
   bit   rnd_car = 1'b0;

   pulse_sequencer #(.TIMER_WIDTH(TW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .sys_rst_n(sys_rst_n), .sym_valid(sym_valid), .sym_ready(sym_ready),
      .sym_level(sym_level), .sym_duration(sym_duration), .start(start), .stop(stop),
      .flush(flush), .idle_level(idle_level), .carrier_mod(carrier_mod),
      .carrier_in(carrier_in),
`ifdef PULSE_SEQ_LOOP_EN
      .loop_count(loop_count),
`endif
      .carrier_gate(carrier_gate), .out(out), .busy(busy), .done(done),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      carrier_in = rnd_car ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
   endtask

   task automatic wr(input logic l, input int d);
      chk("wr_ready", 32'(sym_ready), 32'(q.size() < DEPTH));
      sym_valid = 1'b1; sym_level = l; sym_duration = TW'(d);
      tick();
      sym_valid = 1'b0;
      if (q.size() < DEPTH) q.push_back('{l, d});
      chk("wr_count", 32'(fifo_count), 32'(q.size()));
   endtask

   // Plays the model queue; optional write at the last cycle of symbol wr_after, optional stop at cycle stop_cyc.
   task automatic play(input int wr_after, input int stop_cyc);
      int   g;
      sym_t s;
      logic e;
      g = 0;
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; q.size() > 0; k++) begin
         s = q.pop_front();
         for (int c = 0; c <= s.dur; c++) begin
            e = s.lvl ? (carrier_mod ? carrier_in : 1'b1) : 1'b0;
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_out", 32'(out), 32'(e));
            chk("run_gate", 32'(carrier_gate), 32'(s.lvl & carrier_mod));
            chk("run_done", 32'(done), 32'd0);
            chk("run_count", 32'(fifo_count), 32'(q.size()));
            if (g == stop_cyc) begin
               stop = 1'b1; tick(); stop = 1'b0;
               chk("stop_busy", 32'(busy), 32'd0);
               chk("stop_done", 32'(done), 32'd0);
               chk("stop_count", 32'(fifo_count), 32'(q.size()));
               chk("stop_out", 32'(out), 32'(idle_level));
               return;
            end
            if ((k == wr_after) && (c == s.dur)) begin
               chk("rw_ready", 32'(sym_ready), 32'd1);
               sym_valid = 1'b1; sym_level = 1'b1; sym_duration = TW'(2);
               q.push_back('{1'b1, 2});
            end
            tick();
            sym_valid = 1'b0;
            g++;
         end
      end
      chk("end_busy", 32'(busy), 32'd0);
      chk("end_done", 32'(done), 32'd1);
      chk("end_out", 32'(out), 32'(idle_level));
      chk("end_count", 32'(fifo_count), 32'd0);
      tick();
      chk("done_once", 32'(done), 32'd0);
   endtask

   initial begin
      int wr_idx;
`ifdef PULSE_SEQ_LOOP_EN
      wr_idx = -1;
`else
      wr_idx = 0;
`endif
      // Reset values
      idle_level = 1'b1;
      tick();
      chk("rst_out", 32'(out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_gate", 32'(carrier_gate), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_ready", 32'(sym_ready), 32'd1);
      sys_rst_n = 1'b1;
      tick();
      chk("post_rst_out", 32'(out), 32'd1);

      // Solid marks, then carrier-modulated marks
      idle_level = 1'b0;
      tick();
      wr(1'b1, 9); wr(1'b0, 4); wr(1'b1, 0);
      play(-1, -1);
      carrier_mod = 1'b1; rnd_car = 1'b1;
      wr(1'b1, 9); wr(1'b0, 4); wr(1'b1, 0);
      play(-1, -1);
      carrier_mod = 1'b0; rnd_car = 1'b0;

      // Full FIFO: fifth write dropped; then write coinciding with a reload pop
      for (int i = 0; i < 5; i++) wr(1'(i), i);
      chk("full_count", 32'(fifo_count), 32'(DEPTH));
      play(wr_idx, -1);

      // Stop on the third cycle of the first symbol, then resume
      wr(1'b1, 9); wr(1'b0, 4); wr(1'b1, 0);
      play(-1, 2);
      play(-1, -1);

      // Flush drops a simultaneous write
      wr(1'b1, 3); wr(1'b0, 3);
      flush = 1'b1; sym_valid = 1'b1;
      tick();
      flush = 1'b0; sym_valid = 1'b0;
      q.delete();
      chk("flush_count", 32'(fifo_count), 32'd0);

      // Randomized streams
      for (int r = 0; r < 8; r++) begin
         idle_level  = 1'($urandom_range(0, 1));
         carrier_mod = 1'($urandom_range(0, 1));
         rnd_car     = 1'b1;
         for (int n = 0; n < int'($urandom_range(1, DEPTH)); n++)
            wr(1'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
         play(-1, -1);
      end
      rnd_car = 1'b0; carrier_mod = 1'b0; idle_level = 1'b0;
      tick();

      // Asynchronous reset in the middle of a run
      wr(1'b1, 5); wr(1'b0, 5);
      start = 1'b1; tick(); start = 1'b0;
      tick();
      #1 sys_rst_n = 1'b0;
      #1;
      chk("arst_out", 32'(out), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_count", 32'(fifo_count), 32'd0);
      sys_rst_n = 1'b1;
      q.delete();
      idle_level = 1'b1;
      tick();
      chk("arst_idle_out", 32'(out), 32'd1);
      idle_level = 1'b0;
      tick();

`ifdef PULSE_SEQ_LOOP_EN
      // Three passes of {1,1},{0,1}
      loop_count = 8'd2;
      wr(1'b1, 1); wr(1'b0, 1);
      start = 1'b1; tick(); start = 1'b0;
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 4; i++) begin
            chk("loop_busy", 32'(busy), 32'd1);
            chk("loop_out", 32'(out), 32'(i < 2));
            tick();
         end
      end
      chk("loop_done", 32'(done), 32'd1);
      chk("loop_count", 32'(fifo_count), 32'd0);
      q.delete();
      loop_count = 8'd0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
